// File: rtl/alu_arbiter_pkg.sv
// Shared types and constants for the two-requester ALU front end.
// Holds the FSM state encoding and the ALU op-select codes.
package alu_arbiter_pkg;

    localparam int ALU_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_AND = 2'b01;
    localparam logic [1:0] OP_OR  = 2'b10;
    localparam logic [1:0] OP_XOR = 2'b11;

endpackage

// File: rtl/alu.sv
// Shared combinational 4-bit ALU: add (carry dropped), and, or, xor.
// Driven only from the arbiter's operand registers.
module alu
    import alu_arbiter_pkg::*;
#(
    parameter int W = ALU_W
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic [1:0]   sel_i,
    output logic [W-1:0] y_o
);

    always_comb begin
        y_o = '0;
        unique case (sel_i)
            OP_ADD:  y_o = a_i + b_i;
            OP_AND:  y_o = a_i & b_i;
            OP_OR:   y_o = a_i | b_i;
            OP_XOR:  y_o = a_i ^ b_i;
            default: y_o = '0;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin front end sharing one ALU between two requesters.
// Grants in IDLE, computes in EXEC, holds the response in RESP.
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int W = ALU_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [W-1:0] req0_a,
    input  logic [W-1:0] req0_b,
    input  logic [1:0]   req0_sel,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [W-1:0] req1_a,
    input  logic [W-1:0] req1_b,
    input  logic [1:0]   req1_sel,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic         rsp_id,
    output logic [W-1:0] rsp_result,
    output logic         busy
);

    state_e       state_q, state_d;
    logic         prio_q, prio_d;
    logic         id_q, id_d;
    logic [W-1:0] a_q, a_d;
    logic [W-1:0] b_q, b_d;
    logic [1:0]   sel_q, sel_d;
    logic [W-1:0] res_q, res_d;
    logic         gnt0, gnt1;
    logic [W-1:0] alu_y;

    alu #(.W(W)) u_alu (
        .a_i   (a_q),
        .b_i   (b_q),
        .sel_i (sel_q),
        .y_o   (alu_y)
    );

    always_comb begin
        state_d = state_q;
        prio_d  = prio_q;
        id_d    = id_q;
        a_d     = a_q;
        b_d     = b_q;
        sel_d   = sel_q;
        res_d   = res_q;
        gnt0    = 1'b0;
        gnt1    = 1'b0;
        unique case (state_q)
            IDLE: begin
                // prio names the winner only when both requesters contend
                gnt1 = req1_valid && (!req0_valid || prio_q);
                gnt0 = req0_valid && !gnt1;
                if (gnt0 || gnt1) begin
                    id_d    = gnt1;
                    a_d     = gnt1 ? req1_a : req0_a;
                    b_d     = gnt1 ? req1_b : req0_b;
                    sel_d   = gnt1 ? req1_sel : req0_sel;
                    prio_d  = !gnt1;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                res_d   = alu_y;
                state_d = RESP;
            end
            RESP: begin
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            prio_q  <= 1'b0;
            id_q    <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sel_q   <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            prio_q  <= prio_d;
            id_q    <= id_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sel_q   <= sel_d;
            res_q   <= res_d;
        end
    end

    assign req0_ready = gnt0;
    assign req1_ready = gnt1;
    assign busy       = (state_q != IDLE);
    assign rsp_valid  = (state_q == RESP);
    assign rsp_id     = id_q;
    assign rsp_result = res_q;

endmodule
